// File: rtl/half_adder_if.sv
// Operand/result bundle for half_adder: operand bits and controls in,
// combinational and registered results plus the carry-event count out.
`timescale 1ns/1ps
interface half_adder_if #(
  parameter int CNT_W = 8
);
  logic             a;
  logic             b;
  logic             in_valid;
  logic             clr_cnt;
  logic             sum;
  logic             carry;
  logic             sum_q;
  logic             carry_q;
  logic             out_valid;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output a, b, in_valid, clr_cnt,
    input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );

  modport slave (
    input  a, b, in_valid, clr_cnt,
    output sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );
endinterface

// File: rtl/half_adder.sv
// Half adder with a combinational result, a one-cycle registered result
// qualified by in_valid, and a saturating counter of accepted carry events.
`timescale 1ns/1ps
module half_adder #(
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  half_adder_if.slave bus
);

  logic             sum_q_reg;
  logic             carry_q_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] carry_cnt_reg;
  logic [CNT_W-1:0] carry_cnt_next;

  // Combinational path is deliberately outside reset and in_valid.
  assign bus.sum   = bus.a ^ bus.b;
  assign bus.carry = bus.a & bus.b;

  // Clear wins over a simultaneous increment; all-ones is the saturation point.
  always_comb begin
    carry_cnt_next = carry_cnt_reg;
    if (bus.clr_cnt) begin
      carry_cnt_next = '0;
    end else if (bus.in_valid && bus.carry && (carry_cnt_reg != {CNT_W{1'b1}})) begin
      carry_cnt_next = carry_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q_reg     <= 1'b0;
      carry_q_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      carry_cnt_reg <= '0;
    end else begin
      out_valid_reg <= bus.in_valid;
      carry_cnt_reg <= carry_cnt_next;
      if (bus.in_valid) begin
        sum_q_reg   <= bus.sum;
        carry_q_reg <= bus.carry;
      end
    end
  end

  assign bus.sum_q     = sum_q_reg;
  assign bus.carry_q   = carry_q_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.carry_cnt = carry_cnt_reg;

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: two instances (CNT_W=8 and CNT_W=2) share
// stimulus; expectations come from 2-bit arithmetic and an integer counter model.
`timescale 1ns/1ps
module tb_half_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  half_adder_if #(.CNT_W(8)) bus8 ();
  half_adder_if #(.CNT_W(2)) bus2 ();

  half_adder #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  half_adder #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus2.a        = bus8.a;
  assign bus2.b        = bus8.b;
  assign bus2.in_valid = bus8.in_valid;
  assign bus2.clr_cnt  = bus8.clr_cnt;

  typedef struct { logic ov; int cnt8; int cnt2; } cyc_t;
  typedef struct { logic s; logic c; } res_t;

  cyc_t cyc_q[$];
  res_t res_q[$];
  int   cnt_m8, cnt_m2;
  logic held_s, held_c;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one operand set for the coming edge and record what it must produce.
  task automatic drive_at(input logic a, input logic b, input logic v, input logic clr);
    int   s2;
    cyc_t e;
    res_t r;
    bus8.a = a; bus8.b = b; bus8.in_valid = v; bus8.clr_cnt = clr;
    s2 = int'(a) + int'(b);
    if (clr) begin
      cnt_m8 = 0;
      cnt_m2 = 0;
    end else if (v && s2 == 2) begin
      cnt_m8 = (cnt_m8 < 255) ? cnt_m8 + 1 : 255;
      cnt_m2 = (cnt_m2 < 3) ? cnt_m2 + 1 : 3;
    end
    e.ov = v; e.cnt8 = cnt_m8; e.cnt2 = cnt_m2;
    cyc_q.push_back(e);
    if (v) begin
      r.s = s2[0]; r.c = s2[1];
      res_q.push_back(r);
    end
    #0.01;
    check("comb_sum", {15'd0, bus8.sum}, {15'd0, s2[0]});
    check("comb_carry", {15'd0, bus8.carry}, {15'd0, s2[1]});
  endtask

  task automatic drive(input logic a, input logic b, input logic v, input logic clr);
    @(negedge clk);
    drive_at(a, b, v, clr);
  endtask

  task automatic model_reset();
    cnt_m8 = 0; cnt_m2 = 0;
    held_s = 1'b0; held_c = 1'b0;
    cyc_q.delete();
    res_q.delete();
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_sum_q"}, {15'd0, bus8.sum_q}, 16'd0);
    check({tag, "_carry_q"}, {15'd0, bus8.carry_q}, 16'd0);
    check({tag, "_out_valid"}, {15'd0, bus8.out_valid}, 16'd0);
    check({tag, "_cnt8"}, {8'd0, bus8.carry_cnt}, 16'd0);
    check({tag, "_cnt2"}, {14'd0, bus2.carry_cnt}, 16'd0);
  endtask

  // Monitor: per-cycle state checks, result pops whenever the DUT flags out_valid.
  initial begin
    cyc_t e;
    res_t r;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        check("out_valid8", {15'd0, bus8.out_valid}, {15'd0, e.ov});
        check("out_valid2", {15'd0, bus2.out_valid}, {15'd0, e.ov});
        check("carry_cnt8", {8'd0, bus8.carry_cnt}, 16'(e.cnt8));
        check("carry_cnt2", {14'd0, bus2.carry_cnt}, 16'(e.cnt2));
        if (bus8.out_valid === 1'b1) begin
          if (res_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_result: got out_valid 1, expected no pending result");
          end else begin
            r = res_q.pop_front();
            held_s = r.s; held_c = r.c;
          end
          $display("txn sum_q=%b carry_q=%b cnt8=%0d cnt2=%0d", bus8.sum_q, bus8.carry_q,
                   bus8.carry_cnt, bus2.carry_cnt);
        end
        check("sum_q8", {15'd0, bus8.sum_q}, {15'd0, held_s});
        check("carry_q8", {15'd0, bus8.carry_q}, {15'd0, held_c});
        check("sum_q2", {15'd0, bus2.sum_q}, {15'd0, held_s});
        check("carry_q2", {15'd0, bus2.carry_q}, {15'd0, held_c});
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ab;
    rst_n = 1'b0;
    bus8.a = 1'b0; bus8.b = 1'b0; bus8.in_valid = 1'b0; bus8.clr_cnt = 1'b0;
    model_reset();

    // Combinational sweep while held in reset.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      bus8.a = ab[1]; bus8.b = ab[0];
      #0.01;
      check("sweep_sum", {15'd0, bus8.sum}, 16'((i == 1 || i == 2) ? 1 : 0));
      check("sweep_carry", {15'd0, bus8.carry}, 16'((i == 3) ? 1 : 0));
    end
    check_regs_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    drive_at(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    check("reg_sum_q", {15'd0, bus8.sum_q}, 16'd0);
    check("reg_carry_q", {15'd0, bus8.carry_q}, 16'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("hold_out_valid", {15'd0, bus8.out_valid}, 16'd0);
    check("hold_carry_q", {15'd0, bus8.carry_q}, 16'd1);

    // Counter: 5 carry events interleaved with 3 non-carry accepts.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1 && i < 7) drive(1'b1, 1'b0, 1'b1, 1'b0);
      else drive(1'b1, 1'b1, 1'b1, 1'b0);
    end
    @(posedge clk); #2;
    check("count5_cnt8", {8'd0, bus8.carry_cnt}, 16'd5);

    // Saturation of the narrow counter.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    check("sat_cnt2", {14'd0, bus2.carry_cnt}, 16'd3);
    check("sat_cnt8", {8'd0, bus8.carry_cnt}, 16'd6);

    // Clear beats a simultaneous increment.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #2;
    check("clr_cnt8", {8'd0, bus8.carry_cnt}, 16'd0);
    check("clr_carry_q", {15'd0, bus8.carry_q}, 16'd1);

    // Mid-cycle asynchronous reset with count 4 and a result pending.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #3;
    check("pre_rst_cnt8", {8'd0, bus8.carry_cnt}, 16'd4);
    check("pre_rst_out_valid", {15'd0, bus8.out_valid}, 16'd1);
    rst_n = 1'b0;
    model_reset();
    #0.01;
    check_regs_zero("async_rst");
    check("rst_comb_carry", {15'd0, bus8.carry}, 16'd1);
    bus8.a = 1'b0;
    #0.01;
    check("rst_comb_sum", {15'd0, bus8.sum}, 16'd1);
    check("rst_comb_carry0", {15'd0, bus8.carry}, 16'd0);
    bus8.a = 1'b1;
    @(posedge clk); #1;
    check_regs_zero("rst_discard");
    @(negedge clk);
    rst_n = 1'b1;
    drive_at(1'b1, 1'b1, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("drained_results", 16'(res_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter CNT_W, default 8: width of the carry-event counter, legal range 2..16.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
REQ-004 a  input  1  addend bit A.
REQ-005 b  input  1  addend bit B.
REQ-006 in_valid  input  1  qualifies a/b for the registered path and the counter.
REQ-007 clr_cnt  input  1  synchronous clear of carry_cnt.
REQ-008 sum  output  1  combinational a XOR b.
REQ-009 carry  output  1  combinational a AND b.
REQ-010 sum_q  output  1  registered sum of the last accepted operand pair.
REQ-011 carry_q  output  1  registered carry of the last accepted operand pair.
REQ-012 out_valid  output  1  sum_q/carry_q updated in this cycle.
REQ-013 carry_cnt  output  CNT_W  count of accepted pairs that produced carry=1, saturating.

Function
REQ-014 sum and carry SHALL be purely combinational from a and b, independent of clk, rst_n and in_valid.
REQ-015 sum and carry SHALL settle within one evaluation of an input change, with no clock edge required.
REQ-016 Arithmetic: {carry,sum} SHALL equal a+b as a 2-bit unsigned value.
REQ-017 Truth table: 00->sum 0 carry 0; 01->1,0; 10->1,0; 11->0,1.
REQ-018 On a rising clk with in_valid=1, sum_q<=a^b and carry_q<=a&b, giving a latency of 1 cycle.
REQ-019 On a rising clk with in_valid=1, out_valid<=1; otherwise out_valid<=0.
REQ-020 sum_q and carry_q SHALL hold their values while in_valid=0.
REQ-021 On a rising clk with in_valid=1 and a&b=1, carry_cnt SHALL increment by 1.
REQ-022 carry_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 On a rising clk with clr_cnt=1, carry_cnt SHALL become 0.
REQ-024 clr_cnt SHALL take priority over a simultaneous increment; the result is 0, not 1.
REQ-025 clr_cnt SHALL NOT affect sum_q, carry_q or out_valid.
REQ-026 X/Z on a or b SHALL NOT be masked; propagation follows normal RTL semantics.

Reset
REQ-027 While rst_n=0: sum_q=0, carry_q=0, out_valid=0 and carry_cnt=0, effective immediately without waiting for a clk edge.
REQ-028 Reset SHALL NOT affect the combinational sum and carry outputs.
REQ-029 An assertion of rst_n during an in_valid cycle SHALL discard that operand pair; no count and no out_valid result.
REQ-030 The first rising clk after rst_n returns high SHALL process inputs normally.

Verification
REQ-031 Combinational sweep: apply {a,b}=0..3 with no clock, checking after each 10 ps.
- Required: (0,0)(1,0)(1,0)(0,1) for (sum,carry).
REQ-032 Registered path: in_valid=1 with a=1, b=1 at edge N.
- Required: sum_q=0, carry_q=1, out_valid=1 after edge N.
- Then in_valid=0: out_valid=0 after edge N+1, sum_q/carry_q unchanged.
REQ-033 Counter: 5 cycles of in_valid=1, a=b=1, interleaved with 3 cycles of in_valid=1, a=1, b=0.
- Required: carry_cnt=5.
REQ-034 Saturation (CNT_W=2): 6 accepted carry events.
- Required: carry_cnt=3.
REQ-035 Clear priority: clr_cnt=1 in the same cycle as a=b=1, in_valid=1.
- Required: carry_cnt=0, carry_q=1.
REQ-036 Async reset: drop rst_n mid-cycle with carry_cnt=4 and out_valid=1.
- Required: all registered outputs 0 before the next edge; sum/carry still track a, b.
